// File: rtl/pipe_pkg.sv
// Shared definitions for the operand-read pipeline stage: payload field
// widths and the derived packed payload width.
package pipe_pkg;

  localparam int IMM_W    = 32;
  localparam int XLEN     = 32;
  localparam int FUNCT3_W = 3;
  localparam int FLAGS_W  = 16;
  localparam int RD_W     = 5;

  // Payload = imm, rs1_data, rs2_data, pc, funct3, flags.
  localparam int OP_READ_DATA_W = IMM_W + 3 * XLEN + FUNCT3_W + FLAGS_W;

  localparam int STALL_W = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of the pipeline stage. Captures a beat that arrives
// while the main entry is stalled, hands it to the main entry when that frees.
// in_ready is registered here as "skid entry empty"; it reads 0 under reset.
module pipe_skid_buf #(
  parameter int DATA_W = pipe_pkg::OP_READ_DATA_W,
  parameter int RD_W   = pipe_pkg::RD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [DATA_W-1:0] i_data,
  input  logic [RD_W-1:0]   i_rd,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [RD_W-1:0]   o_rd,
  output logic              o_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;
  logic              r_ready;
  logic              w_valid_next;

  // Occupancy after this edge; flush empties, load fills, drain empties.
  always_comb begin
    w_valid_next = r_valid;
    if (i_flush)      w_valid_next = 1'b0;
    else if (i_load)  w_valid_next = 1'b1;
    else if (i_drain) w_valid_next = 1'b0;
  end

  // Occupancy and ready registers; ready mirrors the next empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_ready <= ~w_valid_next;
    end
  end

  // Payload is written only when a beat is actually parked here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rd   <= '0;
    end else if (i_load && !i_flush) begin
      r_data <= i_data;
      r_rd   <= i_rd;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_rd    = r_rd;
  assign o_ready = r_ready;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register for the operand-read payload, with flush,
// optional bubble zeroing and a saturating stall counter.
// Macro PIPE_STAGE_SKID_EN: defined -> 2-entry (main + skid) with registered
// in_ready; undefined -> single entry with combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = OP_READ_DATA_W,
  parameter int RD_W        = pipe_pkg::RD_W,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [RD_W-1:0]    out_rd,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               stall_clr
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [RD_W-1:0]    r_rd;
  logic [STALL_W-1:0] r_stall_cnt;

  logic               w_main_free;
  logic               w_load_main;
  logic [DATA_W-1:0]  w_next_data;
  logic [RD_W-1:0]    w_next_rd;

  // Main entry can take a new beat when empty or when its beat leaves now.
  assign w_main_free = ~r_valid | out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [RD_W-1:0]   w_skid_rd;
  logic              w_skid_ready;
  logic              w_accept;
  logic              w_skid_load;
  logic              w_skid_drain;

  assign w_accept     = in_valid & w_skid_ready;
  assign w_skid_load  = w_accept & ~w_main_free;
  assign w_skid_drain = w_main_free & w_skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_data  (in_data),
    .i_rd    (in_rd),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_rd    (w_skid_rd),
    .o_ready (w_skid_ready)
  );

  // The skid beat is older than anything on the input, so it refills first.
  assign w_load_main = w_main_free & (w_skid_valid | w_accept);
  assign w_next_data = w_skid_valid ? w_skid_data : in_data;
  assign w_next_rd   = w_skid_valid ? w_skid_rd   : in_rd;
  assign in_ready    = w_skid_ready;
`else
  assign w_load_main = in_valid & w_main_free;
  assign w_next_data = in_data;
  assign w_next_rd   = in_rd;
  assign in_ready    = w_main_free;
`endif

  // Main entry: flush wins, then load, then drain on downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rd    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load_main) begin
      r_valid <= 1'b1;
      r_data  <= w_next_data;
      r_rd    <= w_next_rd;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Stall counter: clear has priority, increments saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !out_ready && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = (ZERO_BUBBLE && !r_valid) ? '0 : r_data;
  assign out_rd    = (ZERO_BUBBLE && !r_valid) ? '0 : r_rd;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 147: payload width (imm, rs1_data, rs2_data, pc, funct3, flags).
- RD_W, 5: destination-register index width.
- ZERO_BUBBLE, 1: when 1, the payload outputs read all-zero whenever out_valid=0.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: upstream offers a beat.
- in_ready, out, 1: stage accepts a beat.
- in_data, in, DATA_W: upstream payload.
- in_rd, in, RD_W: upstream destination index.
- flush, in, 1: kill all held beats (branch or exception).
- out_valid, out, 1: stage presents a beat.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_W: held payload.
- out_rd, out, RD_W: held destination index.
- stall_cnt, out, 16: count of cycles with out_valid=1 and out_ready=0.
- stall_clr, in, 1: synchronous clear of stall_cnt.

Function
REQ-003 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-004 Latency from an accepted input to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-005 Sustained throughput SHALL be 1 beat/cycle while in_valid=1 and out_ready=1.
REQ-006 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated unless flushed.
REQ-007 While out_valid=1 and out_ready=0, out_data and out_rd SHALL hold stable.
REQ-008 A beat on in_data/in_rd SHALL be captured only on an accepting edge.
REQ-009 Flush SHALL take priority over all transfers: on an edge with flush=1, all held beats are discarded and the same-cycle input is not accepted.
REQ-010 On the cycle after a flush, out_valid SHALL be 0.
REQ-011 A flush on an empty stage SHALL have no effect other than REQ-010.
REQ-012 If ZERO_BUBBLE=1, out_data and out_rd SHALL be 0 whenever out_valid=0; if ZERO_BUBBLE=0, they are don't-care.
REQ-013 out_rd=0 on a valid beat SHALL pass through unchanged; the block does not interpret it as "no write".
REQ-014 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, and saturate at 16'hFFFF without wrapping.
REQ-015 stall_clr=1 SHALL set stall_cnt to 0 on the next edge, taking priority over a simultaneous increment.

Reset
REQ-016 On rst_n=0, asynchronously and regardless of clk, the block SHALL drive out_valid=0, out_data=0, out_rd=0 and stall_cnt=0, and empty all internal entries.
REQ-017 Under reset, in_ready SHALL be 0 in skid mode and 1 otherwise.
REQ-018 Reset deassertion mid-stream SHALL resume operation from empty with no spurious out_valid.

Configuration
REQ-019 The macro PIPE_STAGE_SKID_EN SHALL select the stage structure.
- Defined: a 2-entry buffer (main plus skid). in_ready is a pure register output equal to "skid entry empty". A beat arriving while downstream stalls is held in the skid entry and drains next, in order. in_ready returns to 1 one cycle after the skid entry drains.
- Undefined: a single entry. in_ready = out_ready | ~out_valid (combinational). No skid storage.
REQ-020 Both variants SHALL satisfy REQ-003..REQ-015 identically at the port boundary, apart from in_ready timing.

Structure
REQ-021 The shared package pipe_pkg SHALL hold the following; parameter defaults are derived from it:
- Payload field widths: IMM_W=32, XLEN=32, FUNCT3_W=3, FLAGS_W=16, RD_W=5.
- The derived OP_READ_DATA_W.
REQ-022 Skid storage SHALL be a sub-module pipe_skid_buf instantiated only under PIPE_STAGE_SKID_EN; stall_cnt logic stays in pipe_stage_reg.

Verification
REQ-023 Streaming: in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 -> out_data=1,2,3,4 on the following 4 cycles with out_valid=1 throughout.
REQ-024 Backpressure: beat A=0xAA accepted, then out_ready=0 for 3 cycles while B=0xBB is offered -> out_data holds 0xAA and stall_cnt=3. With skid enabled, B is accepted into the skid entry and in_ready=0 thereafter. On out_ready=1, A then B emerge.
REQ-025 Flush: stage holding one or two beats plus flush=1 with in_valid=1 (data 0x55) -> next cycle out_valid=0, out_data=0, out_rd=0; 0x55 is never output.
REQ-026 Async reset: assert rst_n=0 between clock edges while out_valid=1 -> out_valid=0 and stall_cnt=0 immediately; after release, no output until a new accepted beat.
REQ-027 Counter: hold out_valid=1 with out_ready=0 for 65540 cycles -> stall_cnt=16'hFFFF. Then assert stall_clr together with a stall cycle -> stall_cnt=0.
